// File: rtl/hue_stage1.sv
// First hue pipeline stage: finds max/min/delta of an RGB pixel and computes the signed
// sextant-relative hue 60*num/delta with a 6-step restoring divider (fixed 10-cycle cadence).
module hue_stage1 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [DATA_W-1:0] i_red,
  input  logic [DATA_W-1:0] i_green,
  input  logic [DATA_W-1:0] i_blue,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [15:0]       o_data,
  output logic [1:0]        o_function,
  output logic              o_valid
);

  localparam int unsigned DivW = DATA_W + 6;

  typedef enum logic [1:0] {StIdle, StSetup, StDiv, StDone} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] red_q, green_q, blue_q;
  logic [DivW-1:0]   rem_q, dvs_q;
  logic [5:0]        quo_q;
  logic [2:0]        cnt_q;
  logic              neg_q;
  logic [1:0]        func_q;

  logic [DATA_W-1:0] max_c, min_c, delta_c;
  logic [DATA_W:0]   num_c, abs_c;
  logic [1:0]        func_c;
  logic [DivW-1:0]   dividend_c;
  logic [15:0]       quo_ext;

  // Max selection with ties resolved R > G > B; function code 0 marks a gray pixel.
  always_comb begin
    max_c  = red_q;
    func_c = 2'd1;
    num_c  = {1'b0, green_q} - {1'b0, blue_q};
    if (!(red_q >= green_q && red_q >= blue_q)) begin
      if (green_q >= blue_q) begin
        max_c  = green_q;
        func_c = 2'd2;
        num_c  = {1'b0, blue_q} - {1'b0, red_q};
      end else begin
        max_c  = blue_q;
        func_c = 2'd3;
        num_c  = {1'b0, red_q} - {1'b0, green_q};
      end
    end
    min_c = red_q;
    if (green_q < min_c) min_c = green_q;
    if (blue_q < min_c)  min_c = blue_q;
    delta_c = max_c - min_c;
    if (delta_c == '0) func_c = 2'd0;
    abs_c      = num_c[DATA_W] ? -num_c : num_c;
    dividend_c = DivW'(abs_c[DATA_W-1:0]) * DivW'(60);
  end

  assign quo_ext = {10'b0, quo_q};

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= StIdle;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      func_q     <= '0;
      o_ready    <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_function <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          // o_ready rises one edge after DONE (or after reset release)
          if (o_ready && i_valid) begin
            red_q   <= i_red;
            green_q <= i_green;
            blue_q  <= i_blue;
            o_ready <= 1'b0;
            state_q <= StSetup;
          end else begin
            o_ready <= 1'b1;
          end
        end
        StSetup: begin
          func_q  <= func_c;
          neg_q   <= num_c[DATA_W];
          rem_q   <= dividend_c;
          dvs_q   <= {1'b0, delta_c, 5'b0};
          quo_q   <= '0;
          cnt_q   <= '0;
          state_q <= StDiv;
        end
        StDiv: begin
          // Divisor is pre-shifted by 5 and walks right, yielding quotient bits MSB first
          if (func_q != 2'd0 && rem_q >= dvs_q) begin
            rem_q <= rem_q - dvs_q;
            quo_q <= {quo_q[4:0], 1'b1};
          end else begin
            quo_q <= {quo_q[4:0], 1'b0};
          end
          dvs_q <= dvs_q >> 1;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd5) state_q <= StDone;
        end
        StDone: begin
          o_valid    <= 1'b1;
          o_function <= func_q;
          o_data     <= neg_q ? -quo_ext : quo_ext;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hue_stage1.sv
// Self-checking bench for hue_stage1: directed cases, cycle-exact timing, reset abort and
// randomized pixels against an integer reference of the hue formula.
module tb_hue_stage1;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic [7:0]  i_red, i_green, i_blue;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] o_data;
  logic [1:0]  o_function;
  logic        o_valid;

  int n_checks = 0;
  int n_pass   = 0;

  hue_stage1 #(.DATA_W(8)) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_red      (i_red),
    .i_green    (i_green),
    .i_blue     (i_blue),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_function (o_function),
    .o_valid    (o_valid)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  // Reference: {function, data} straight from the hue formula using integer arithmetic.
  function automatic logic [17:0] ref_hue(input int r, input int g, input int b);
    int mx, mn, num, fn, d, q;
    if (r >= g && r >= b) begin mx = r; num = g - b; fn = 1; end
    else if (g >= b)      begin mx = g; num = b - r; fn = 2; end
    else                  begin mx = b; num = r - g; fn = 3; end
    mn = r;
    if (g < mn) mn = g;
    if (b < mn) mn = b;
    d = mx - mn;
    if (d == 0) return 18'd0;
    q = (60 * (num < 0 ? -num : num)) / d;
    if (num < 0) q = -q;
    return {fn[1:0], q[15:0]};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (o_ready) return;
      tick();
    end
    check("wait_ready_timeout", {31'b0, o_ready}, 32'd1);
  endtask

  task automatic drive(input int r, input int g, input int b, input logic v);
    i_red   = 8'(r);
    i_green = 8'(g);
    i_blue  = 8'(b);
    i_valid = v;
  endtask

  // Accept one pixel at edge 0 and check the full 10-edge timeline; busy cycles get noise.
  task automatic run_pixel(input string tag, input int r, input int g, input int b);
    logic [17:0] exp;
    logic        early;
    exp = ref_hue(r, g, b);
    wait_ready();
    drive(r, g, b, 1'b1);
    tick();
    early = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      drive($urandom_range(255), $urandom_range(255), $urandom_range(255), 1'($urandom_range(1)));
      tick();
      if (o_valid || o_ready) early = 1'b1;
    end
    tick();
    check({tag, "_busy"}, {31'b0, early}, 32'd0);
    check({tag, "_valid"}, {31'b0, o_valid}, 32'd1);
    check({tag, "_data"}, {16'b0, o_data}, {16'b0, exp[15:0]});
    check({tag, "_func"}, {30'b0, o_function}, {30'b0, exp[17:16]});
    tick();
    check({tag, "_vfall_rdy"}, {30'b0, o_valid, o_ready}, 32'd1);
    i_valid = 1'b0;
  endtask

  int          tr [20], tg [20], tb [20];
  int          pulses;
  logic [17:0] e0;
  logic        aborted;

  initial begin
    i_rstn = 1'b0;
    drive(0, 0, 0, 1'b0);
    repeat (3) tick();
    check("rst_outputs", {12'b0, o_ready, o_valid, o_function, o_data}, 32'd0);

    // i_valid high at the releasing edge must not be accepted
    drive(1, 2, 3, 1'b1);
    i_rstn = 1'b1;
    tick();
    check("rst_release_ready", {31'b0, o_ready}, 32'd1);
    i_valid = 1'b0;
    tick();
    check("rst_release_no_accept", {31'b0, o_ready}, 32'd1);

    run_pixel("r_max", 200, 100, 50);
    check("r_max_abs", {16'b0, o_data}, 32'd20);
    run_pixel("g_max", 10, 200, 100);
    check("g_max_abs", {16'b0, o_data}, 32'd28);
    run_pixel("b_max", 100, 20, 250);
    check("b_max_abs", {16'b0, o_data}, 32'd20);
    run_pixel("rb_tie", 255, 0, 255);
    check("rb_tie_abs", {14'b0, o_function, o_data}, {14'b0, 2'd1, 16'hFFC4});
    run_pixel("rg_tie", 255, 255, 0);
    check("rg_tie_abs", {16'b0, o_data}, 32'd60);
    run_pixel("gray", 77, 77, 77);
    tick();
    check("hold_after_valid", {14'b0, o_function, o_data}, 32'd0);

    // i_valid held high with a new pixel every cycle
    run_pixel("pre_tp", 200, 100, 50);
    wait_ready();
    pulses = 0;
    for (int e = 0; e < 20; e++) begin
      tr[e] = $urandom_range(255);
      tg[e] = $urandom_range(255);
      tb[e] = $urandom_range(255);
      drive(tr[e], tg[e], tb[e], 1'b1);
      tick();
      if (o_valid) pulses++;
      check($sformatf("tp_ready_e%0d", e), {31'b0, o_ready}, {31'b0, (e == 9 || e == 19)});
      check($sformatf("tp_valid_e%0d", e), {31'b0, o_valid}, {31'b0, (e == 8 || e == 18)});
      if (e == 8 || e == 18) begin
        e0 = ref_hue(tr[e-8], tg[e-8], tb[e-8]);
        check($sformatf("tp_result_e%0d", e), {14'b0, o_function, o_data}, {14'b0, e0});
      end
    end
    i_valid = 1'b0;
    check("tp_pulses", pulses, 32'd2);

    // Reset mid-divide: low at edges 4-5, released at edge 6, new pixel accepted at edge 7
    run_pixel("pre_rst", 200, 100, 50);
    wait_ready();
    drive(10, 200, 100, 1'b1);
    tick();
    i_valid = 1'b0;
    aborted = 1'b0;
    repeat (3) begin tick(); if (o_valid) aborted = 1'b1; end
    i_rstn = 1'b0;
    tick();
    check("midrst_outputs", {12'b0, o_ready, o_valid, o_function, o_data}, 32'd0);
    tick();
    i_rstn = 1'b1;
    drive(100, 20, 250, 1'b1);
    tick();
    check("midrst_ready_e6", {31'b0, o_ready}, 32'd1);
    tick();
    i_valid = 1'b0;
    check("midrst_accept_e7", {31'b0, o_ready}, 32'd0);
    for (int e = 8; e <= 14; e++) begin
      tick();
      if (o_valid) aborted = 1'b1;
    end
    check("midrst_no_stray_valid", {31'b0, aborted}, 32'd0);
    tick();
    check("midrst_valid_e15", {31'b0, o_valid}, 32'd1);
    check("midrst_result", {14'b0, o_function, o_data}, {14'b0, 2'd3, 16'd20});

    // Randomized pixels, biased toward gray and ties
    for (int n = 0; n < 60; n++) begin
      int r, g, b;
      r = $urandom_range(255);
      g = $urandom_range(255);
      b = $urandom_range(255);
      case ($urandom_range(7))
        0: begin g = r; b = r; end
        1: g = r;
        2: b = g;
        3: b = r;
        default: ;
      endcase
      run_pixel($sformatf("rand%0d", n), r, g, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
